registers_tx_block: RTL

REGISTERS_TX_BLOCK -- requirements
Module: registers_tx_block

---
 rtl/registers_tx_block.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/registers_tx_block.sv
// Shadows register-bus writes and streams them out as a byte frame on request.
// Define REGS_TX_CHECKSUM_EN to append an XOR checksum byte to every frame.
module registers_tx_block #(
    parameter int unsigned REG_ADDR_WIDTH = 8,
    parameter int unsigned REG_DATA_WIDTH = 16,
    parameter int unsigned TX_DATA_WIDTH  = 8,
    parameter int unsigned NUM_REGS       = 16,
    parameter logic [7:0]  HEADER         = 8'hA5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] register_addr,
    input  logic [REG_DATA_WIDTH-1:0] register_data,
    input  logic                      register_rdy,
    input  logic                      rqst_regs,
    output logic [TX_DATA_WIDTH-1:0]  tx_data,
    output logic                      tx_rdy,
    output logic                      tx_eof,
    input  logic                      tx_ack,
    output logic                      busy
);

    localparam int unsigned IdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REGS - 1);

`ifdef REGS_TX_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StHdr, StAddr, StDataH, StDataL, StChk} state_e;
`else
    typedef enum logic [2:0] {StIdle, StHdr, StAddr, StDataH, StDataL} state_e;
`endif

    state_e                    state_q, state_d;
    logic [IdxW-1:0]           idx_q, idx_d;
    logic [REG_DATA_WIDTH-1:0] word_q;
    logic [REG_DATA_WIDTH-1:0] shadow_q [NUM_REGS];
    logic                      xfer, last_idx, enter_addr, wr_en;

    assign xfer     = tx_rdy & tx_ack;
    assign last_idx = (idx_q == LastIdx);
    assign wr_en    = register_rdy && (32'(register_addr) < NUM_REGS);

    // Shadow table is writable in every state, independent of the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                shadow_q[i] <= '0;
            end
        end else if (wr_en) begin
            shadow_q[register_addr[IdxW-1:0]] <= register_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (rqst_regs) state_d = StHdr;
            StHdr:   if (xfer) state_d = StAddr;
            StAddr:  if (xfer) state_d = StDataH;
            StDataH: if (xfer) state_d = StDataL;
`ifdef REGS_TX_CHECKSUM_EN
            StDataL: if (xfer) state_d = last_idx ? StChk : StAddr;
            StChk:   if (xfer) state_d = StIdle;
`else
            StDataL: if (xfer) state_d = last_idx ? StIdle : StAddr;
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        enter_addr = xfer && ((state_q == StHdr) || ((state_q == StDataL) && !last_idx));
        idx_d      = idx_q;
        if (state_q == StIdle) begin
            idx_d = '0;
        end else if (xfer && (state_q == StDataL) && !last_idx) begin
            idx_d = idx_q + 1'b1;
        end
    end

    // The word is snapshotted on entry to ADDR so later writes cannot tear its bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q <= idx_d;
            if (enter_addr) begin
                word_q <= shadow_q[idx_d];
            end
        end
    end

`ifdef REGS_TX_CHECKSUM_EN
    logic [TX_DATA_WIDTH-1:0] chk_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_q <= '0;
        end else if (state_q == StIdle) begin
            chk_q <= '0;
        end else if (xfer) begin
            chk_q <= chk_q ^ tx_data;
        end
    end
`endif

    always_comb begin
        tx_rdy  = (state_q != StIdle);
        busy    = (state_q != StIdle);
        tx_data = '0;
        tx_eof  = 1'b0;
        unique case (state_q)
            StHdr:   tx_data = TX_DATA_WIDTH'(HEADER);
            StAddr:  tx_data = TX_DATA_WIDTH'(idx_q);
            StDataH: tx_data = TX_DATA_WIDTH'(word_q[15:8]);
            StDataL: begin
                tx_data = TX_DATA_WIDTH'(word_q[7:0]);
`ifndef REGS_TX_CHECKSUM_EN
                tx_eof  = last_idx;
`endif
            end
`ifdef REGS_TX_CHECKSUM_EN
            StChk: begin
                tx_data = chk_q;
                tx_eof  = 1'b1;
            end
`endif
            default: tx_data = '0;
        endcase
    end

endmodule
